// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end for a multi-cycle core. A two-state FSM
// alternates between requesting one word from instruction memory (FETCH)
// and presenting that word to the controller/datapath until it is consumed
// (HOLD). With a zero-wait memory the stage delivers one instruction every
// two cycles.
//
// Handshakes:
//   imem side : imem_req is a level request. The request completes on any
//               rising edge where imem_req=1 and imem_ack=1; imem_rdata is
//               taken on that edge. imem_addr stays stable while
//               imem_req=1 and imem_ack=0. imem_ack is ignored when no
//               request is outstanding.
//   consumer  : InstrValid=1 means Instr/PCPlus8 hold a fetched word that
//               has not yet been consumed. A transfer happens on a rising
//               edge where InstrValid=1 and InstrReady=1; PCSrc/Result are
//               looked at only on that edge. InstrReady is ignored while
//               InstrValid=0.
//
// Parameters:
//   RESET_PC      word-aligned address fetched first after reset
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         synchronous active-high reset, overrides every input
//   imem_req      instruction memory read request (0 during reset cycles)
//   imem_addr     read address, always word aligned
//   imem_rdata    read data, valid when imem_ack=1
//   imem_ack      read complete (same cycle as imem_req or later)
//   Instr         held instruction word
//   InstrValid    Instr holds a fetched, not-yet-consumed instruction
//   InstrReady    downstream consumes Instr this cycle
//   PCPlus8       PC of the held instruction + 8 (architectural PC read)
//   PCSrc         held instruction redirects the PC
//   Result        redirect target, bits [1:0] dropped
//   FetchCount    (FETCH_PERF_EN only) consumed instructions, wraps
//   RedirectCount (FETCH_PERF_EN only) taken redirects, saturates
//   state_dbg     current FSM state (0=FETCH, 1=HOLD) for checkers
//
// Build option:
//   FETCH_PERF_EN  define to add the FetchCount/RedirectCount counters.
//                  Without it those ports and registers do not exist and
//                  the rest of the behaviour is unchanged.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] PCPlus8,
  input  logic        PCSrc,
  input  logic [31:0] Result,
`ifdef FETCH_PERF_EN
  output logic [31:0] FetchCount,
  output logic [15:0] RedirectCount,
`endif
  output logic        state_dbg
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  // Word-aligned form of the reset address; the low bits of the parameter
  // are never allowed onto imem_addr.
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic [31:0] instr_q;
  logic [31:0] instr_n;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        consume;
  logic        capture;

  // The low two bits of Result carry no address information.
  logic        unused_result_bits;
  assign unused_result_bits = ^Result[1:0];

  // Both adders wrap naturally modulo 2^32.
  assign pc_plus4    = pc + 32'd4;
  assign redirect_pc = {Result[31:2], 2'b00};

  // A word is captured only while a request is outstanding, and consumed
  // only while one is held; the other input in each state is don't-care.
  assign capture = (state == S_FETCH) && imem_ack;
  assign consume = (state == S_HOLD) && InstrReady;

  // -------------------------------------------------------------------------
  // Next-state / datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    case (state)
      S_FETCH: begin
        if (capture) begin
          instr_n = imem_rdata;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (consume) begin
          pc_n    = PCSrc ? redirect_pc : pc_plus4;
          state_n = S_FETCH;
        end
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC_W;
      instr_q <= 32'h0000_0000;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instr_q <= instr_n;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The request is masked by reset so that an edge which both resets and
  // acks cannot be mistaken for a completed fetch, and so the first request
  // appears in the cycle after reset drops.
  assign imem_req   = (state == S_FETCH) && !reset;
  assign imem_addr  = pc;
  assign Instr      = instr_q;
  assign InstrValid = (state == S_HOLD);
  assign PCPlus8    = pc + 32'd8;
  assign state_dbg  = state;

`ifdef FETCH_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
  logic [31:0] fetch_count_q;
  logic [15:0] redirect_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q    <= 32'h0;
      redirect_count_q <= 16'h0;
    end else if (consume) begin
      fetch_count_q <= fetch_count_q + 32'd1;
      if (PCSrc && (redirect_count_q != 16'hFFFF)) begin
        redirect_count_q <= redirect_count_q + 16'd1;
      end
    end
  end

  assign FetchCount    = fetch_count_q;
  assign RedirectCount = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage with RESET_PC=0x100. A memory responder
// answers requests after a programmable number of wait cycles with
// rdata = addr ^ 32'h5A5A0000 (or a poison word when an ack is forced
// outside a request). The main sequence pushes hand-computed expectations
// into two queues (request addresses and consumed {Instr, PCPlus8} pairs);
// a monitor pops and compares whenever the DUT completes a memory handshake
// or hands an instruction downstream. Per-cycle directed checks cover
// reset, stalls, hold stability and wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] PCPlus8;
  logic        PCSrc;
  logic [31:0] Result;
  logic        state_dbg;
`ifdef FETCH_PERF_EN
  logic [31:0] FetchCount;
  logic [15:0] RedirectCount;
`endif

  int total;
  int bad;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_q[$];

  int  ack_wait;
  int  wcnt;
  logic force_ack;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .Instr        (Instr),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .PCPlus8      (PCPlus8),
    .PCSrc        (PCSrc),
    .Result       (Result),
`ifdef FETCH_PERF_EN
    .FetchCount   (FetchCount),
    .RedirectCount(RedirectCount),
`endif
    .state_dbg    (state_dbg)
  );

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Check helper
  // -------------------------------------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: inputs change 1 time unit after the rising edge, then the
  // caller samples outputs on the falling edge.
  // -------------------------------------------------------------------------
  task automatic cyc(input logic r, input logic rdy, input logic ps,
                     input logic [31:0] res, input logic fa);
    @(posedge clk);
    #1;
    reset      = r;
    InstrReady = rdy;
    PCSrc      = ps;
    Result     = res;
    force_ack  = fa;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] ins, input logic [31:0] p8);
    exp_addr_q.push_back(addr);
    exp_q.push_back({ins, p8});
  endtask

  // Memory responder: decides the ack for the coming edge 2 units after
  // the previous one, once imem_req has settled.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    wcnt       = 0;
    forever begin
      @(posedge clk);
      #2;
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        wcnt       = 0;
      end else if (imem_req) begin
        if (wcnt >= ack_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ 32'h5A5A_0000;
          wcnt       = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'h0;
          wcnt++;
        end
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        wcnt       = 0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard monitor
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] ea;
    logic [63:0] ei;
    forever begin
      @(negedge clk);
      if (!reset && imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_req", {32'h0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("req_addr", {32'h0, imem_addr}, {32'h0, ea});
        end
      end
      if (!reset && InstrValid && InstrReady) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_consume", {Instr, PCPlus8}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ei = exp_q.pop_front();
          chk("consume_instr_pcplus8", {Instr, PCPlus8}, ei);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    InstrReady = 1'b0;
    PCSrc      = 1'b0;
    Result     = 32'h0;
    force_ack  = 1'b0;
    ack_wait   = 0;

    // Reset, including an InstrReady that reset must override.
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 1, 0, 32'h0, 0);
    chk("rst_req",   {63'h0, imem_req},   64'h0);
    chk("rst_valid", {63'h0, InstrValid}, 64'h0);
    chk("rst_instr", {32'h0, Instr},      64'h0);
    chk("rst_addr",  {32'h0, imem_addr},  64'h100);

    // Zero-wait streaming: 0x100, 0x104, 0x108, InstrValid toggles.
    push(32'h100, 32'h5A5A_0100, 32'h108);
    push(32'h104, 32'h5A5A_0104, 32'h10C);
    push(32'h108, 32'h5A5A_0108, 32'h110);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 1, 0, 32'h0, 0);
      chk("stream_valid", {63'h0, InstrValid}, {63'h0, k[0]});
      chk("stream_req",   {63'h0, imem_req},   {63'h0, ~k[0]});
    end
    // Hold of 0x108: redirect with unaligned target 0x107 -> 0x104.
    cyc(0, 1, 1, 32'h107, 0);
    chk("hold108_pcplus8", {32'h0, PCPlus8}, 64'h110);

    // Three wait cycles at 0x104; PCSrc/Result/InstrReady ignored in FETCH.
    ack_wait = 3;
    push(32'h104, 32'h5A5A_0104, 32'h10C);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 1, 32'h300, 0);
      chk("stall_addr",  {32'h0, imem_addr},  64'h104);
      chk("stall_req",   {63'h0, imem_req},   64'h1);
      chk("stall_valid", {63'h0, InstrValid}, 64'h0);
      chk("stall_instr", {32'h0, Instr},      64'h5A5A_0108);
    end

    // Hold for 5 cycles with InstrReady=0; stray acks must not disturb Instr.
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 1, 32'h300, 1);
      chk("hold_valid",   {63'h0, InstrValid}, 64'h1);
      chk("hold_instr",   {32'h0, Instr},      64'h5A5A_0104);
      chk("hold_pcplus8", {32'h0, PCPlus8},    64'h10C);
      chk("hold_req",     {63'h0, imem_req},   64'h0);
    end

    // Redirect to 0x203 -> 0x200.
    ack_wait = 0;
    push(32'h200, 32'h5A5A_0200, 32'h208);
    cyc(0, 1, 1, 32'h203, 0);
    chk("redir_valid", {63'h0, InstrValid}, 64'h1);
    cyc(0, 1, 0, 32'h0, 0);
    chk("redir_addr", {32'h0, imem_addr}, 64'h200);
    chk("redir_req",  {63'h0, imem_req},  64'h1);

    push(32'h204, 32'h5A5A_0204, 32'h20C);
    cyc(0, 1, 0, 32'h0, 0);
    chk("hold200_pcplus8", {32'h0, PCPlus8}, 64'h208);
    cyc(0, 1, 0, 32'h0, 0);

    // Redirect to the top word and wrap back to 0.
    push(32'hFFFF_FFFC, 32'hA5A5_FFFC, 32'h4);
    cyc(0, 1, 1, 32'hFFFF_FFFF, 0);
    cyc(0, 1, 0, 32'h0, 0);
    chk("top_addr", {32'h0, imem_addr}, 64'hFFFF_FFFC);
    push(32'h0, 32'h5A5A_0000, 32'h8);
    cyc(0, 1, 0, 32'h0, 0);
    chk("top_pcplus8_wrap", {32'h0, PCPlus8}, 64'h4);
    chk("top_instr",        {32'h0, Instr},   64'hA5A5_FFFC);
    cyc(0, 1, 0, 32'h0, 0);
    chk("wrap_addr", {32'h0, imem_addr}, 64'h0);

    // Consume word 0; then abandon the fetch of 0x4 with reset + ack.
    ack_wait = 3;
    cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 1, 0, 32'h0, 0);
    chk("inflight_addr", {32'h0, imem_addr}, 64'h4);
    chk("inflight_req",  {63'h0, imem_req},  64'h1);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_count",    {32'h0, FetchCount},    64'd8);
    chk("perf_redirect_count", {48'h0, RedirectCount}, 64'd3);
`endif
    cyc(1, 1, 0, 32'h0, 1);
    chk("rst_ack_req", {63'h0, imem_req}, 64'h0);

    ack_wait = 0;
    push(32'h100, 32'h5A5A_0100, 32'h108);
    cyc(0, 1, 0, 32'h0, 0);
    chk("post_rst_valid", {63'h0, InstrValid}, 64'h0);
    chk("post_rst_addr",  {32'h0, imem_addr},  64'h100);
    chk("post_rst_instr", {32'h0, Instr},      64'h0);
    chk("post_rst_req",   {63'h0, imem_req},   64'h1);
    cyc(0, 1, 0, 32'h0, 0);
    chk("post_rst_hold_instr", {32'h0, Instr}, 64'h5A5A_0100);

    // Park in FETCH with memory silent and drain.
    ack_wait = 1000;
    cyc(0, 0, 0, 32'h0, 0);
    cyc(0, 0, 0, 32'h0, 0);
    chk("park_addr", {32'h0, imem_addr}, 64'h104);
`ifdef FETCH_PERF_EN
    chk("perf_fetch_after_rst",    {32'h0, FetchCount},    64'd1);
    chk("perf_redirect_after_rst", {48'h0, RedirectCount}, 64'd0);
`endif
    chk("addr_queue_empty",  {32'h0, 32'(exp_addr_q.size())}, 64'h0);
    chk("instr_queue_empty", {32'h0, 32'(exp_q.size())},      64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
